// File: rtl/ddfs_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddfs_sweep_ctrl_pkg
// Description : Shared widths, FSM state encoding and sweep-mode constants
//               for the DDFS frequency-sweep sequencer (FW width is also the
//               width of ddfs.fw).
// Revision    : 1.0 - initial release
// ============================================================================
package ddfs_sweep_ctrl_pkg;

  localparam int DDFS_FW_W    = 7;
  localparam int DDFS_DWELL_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DWELL = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] M_UP       = 2'b00;
  localparam logic [1:0] M_DOWN     = 2'b01;
  localparam logic [1:0] M_PINGPONG = 2'b10;
  localparam logic [1:0] M_SAW      = 2'b11;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/ddfs_dwell_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ddfs_dwell_cnt
// Description : Counts waveform-period wraps while enabled and flags the wrap
//               that completes a dwell. A target of 0 behaves like 1.
// Revision    : 1.0 - initial release
// ============================================================================
module ddfs_dwell_cnt
  import ddfs_sweep_ctrl_pkg::*;
#(
  parameter int DWELL_W = DDFS_DWELL_W
) (
  input  logic               clk_div,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               wrap,
  input  logic [DWELL_W-1:0] target,
  output logic               expire
);

  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_last;

  // Index of the final wrap in a dwell; target 0 maps to a one-period dwell.
  assign w_last = (target == '0) ? '0 : target - DWELL_W'(1);
  assign expire = wrap && !clear && (r_cnt == w_last);

  // Wrap counter: held at zero while cleared, restarts after each expiry.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (wrap) begin
      r_cnt <= expire ? '0 : r_cnt + DWELL_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddfs_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ddfs_sweep_ctrl
// Description : Frequency-sweep sequencer. Steps the DDFS frequency word
//               between lo and hi (single up/down, ping-pong, sawtooth),
//               updating only one cycle after a dwell's last period wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module ddfs_sweep_ctrl
  import ddfs_sweep_ctrl_pkg::*;
#(
  parameter int FW_W    = DDFS_FW_W,
  parameter int DWELL_W = DDFS_DWELL_W
) (
  input  logic               clk_div,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [FW_W-1:0]    fw_start,
  input  logic [FW_W-1:0]    fw_stop,
  input  logic [FW_W-1:0]    fw_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               period_wrap,
  output logic [FW_W-1:0]    fw,
  output logic               busy,
  output logic               step_strobe,
  output logic               done
);

  state_t r_state, w_state_nxt;

  logic [1:0]         r_mode;
  logic [FW_W-1:0]    r_lo, r_hi, r_step;
  logic [DWELL_W-1:0] r_dwell;

  logic [FW_W-1:0] r_fw, w_fw_nxt;
  logic            r_dir, w_dir_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_strobe, w_strobe_nxt;
  logic            r_done, w_done_nxt;

  logic            w_cfg_load;
  logic [FW_W-1:0] w_in_lo, w_in_hi;
  logic [FW_W:0]   w_sum, w_diff;
  logic [FW_W-1:0] w_next_up, w_next_dn;
  logic            w_expire, w_cnt_clear;

  assign w_cfg_load = (r_state == S_IDLE) && start && !abort;
  assign w_in_lo    = (fw_start <= fw_stop) ? fw_start : fw_stop;
  assign w_in_hi    = (fw_start <= fw_stop) ? fw_stop  : fw_start;

  // One extra bit keeps the carry/borrow so saturation never wraps around.
  assign w_sum     = {1'b0, r_fw} + {1'b0, r_step};
  assign w_diff    = {1'b0, r_fw} - {1'b0, r_step};
  assign w_next_up = (w_sum >= {1'b0, r_hi}) ? r_hi : w_sum[FW_W-1:0];
  assign w_next_dn = (w_diff[FW_W] || (w_diff[FW_W-1:0] <= r_lo)) ? r_lo : w_diff[FW_W-1:0];

  // Wraps are only counted in DWELL; LOAD and STEP keep the counter cleared.
  assign w_cnt_clear = (r_state != S_DWELL);

  ddfs_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk_div (clk_div),
    .rst_n   (rst_n),
    .clear   (w_cnt_clear),
    .wrap    (period_wrap),
    .target  (r_dwell),
    .expire  (w_expire)
  );

  // Sweep configuration captured on an accepted start; step 0 behaves as 1.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= M_UP;
      r_lo    <= '0;
      r_hi    <= '0;
      r_step  <= '0;
      r_dwell <= '0;
    end else if (w_cfg_load) begin
      r_mode  <= mode;
      r_lo    <= w_in_lo;
      r_hi    <= w_in_hi;
      r_step  <= (fw_step == '0) ? FW_W'(1) : fw_step;
      r_dwell <= dwell;
    end
  end

  // State, direction and registered outputs.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_fw     <= '0;
      r_dir    <= DIR_UP;
      r_busy   <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fw     <= w_fw_nxt;
      r_dir    <= w_dir_nxt;
      r_busy   <= w_busy_nxt;
      r_strobe <= w_strobe_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; abort overrides every transition.
  always_comb begin
    w_state_nxt  = r_state;
    w_fw_nxt     = r_fw;
    w_dir_nxt    = r_dir;
    w_strobe_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_fw_nxt    = (mode == M_DOWN) ? w_in_hi : w_in_lo;
          w_dir_nxt   = (mode == M_DOWN) ? DIR_DOWN : DIR_UP;
        end
      end
      S_LOAD:  w_state_nxt = S_DWELL;
      S_DWELL: if (w_expire) w_state_nxt = S_STEP;
      S_STEP: begin
        w_state_nxt = S_DWELL;
        case (r_mode)
          M_UP: begin
            if (r_fw == r_hi) begin
              w_state_nxt = S_DONE;
            end else begin
              w_fw_nxt     = w_next_up;
              w_strobe_nxt = 1'b1;
            end
          end
          M_DOWN: begin
            if (r_fw == r_lo) begin
              w_state_nxt = S_DONE;
            end else begin
              w_fw_nxt     = w_next_dn;
              w_strobe_nxt = 1'b1;
            end
          end
          M_PINGPONG: begin
            // A degenerate range has nowhere to go, so fw simply holds.
            if (r_lo != r_hi) begin
              w_strobe_nxt = 1'b1;
              if (r_dir == DIR_UP) begin
                if (r_fw == r_hi) begin
                  w_dir_nxt = DIR_DOWN;
                  w_fw_nxt  = w_next_dn;
                end else begin
                  w_fw_nxt  = w_next_up;
                end
              end else begin
                if (r_fw == r_lo) begin
                  w_dir_nxt = DIR_UP;
                  w_fw_nxt  = w_next_up;
                end else begin
                  w_fw_nxt  = w_next_dn;
                end
              end
            end
          end
          M_SAW: begin
            w_fw_nxt     = (r_fw == r_hi) ? r_lo : w_next_up;
            w_strobe_nxt = 1'b1;
          end
        endcase
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort) begin
      w_state_nxt  = S_IDLE;
      w_fw_nxt     = r_fw;
      w_dir_nxt    = r_dir;
      w_strobe_nxt = 1'b0;
    end

    w_done_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_DWELL) ||
                 (w_state_nxt == S_STEP);
  end

  assign fw          = r_fw;
  assign busy        = r_busy;
  assign step_strobe = r_strobe;
  assign done        = r_done;

endmodule
`default_nettype wire
